spi_write_controller: RTL and testbench



---
 rtl/spi_write_controller.sv | 156 +++++++++++++++
 tb/tb_spi_write_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_controller.sv
// Write-only SPI mode-0 initiator: turns one accepted address/data request into a
// 16-bit frame {1'b1, addr[6:0], data[7:0]} on ncs/sclk/copi, MSB first.
module spi_write_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned IDLE_GAP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_e;

  localparam logic [7:0] DIV_M1  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_M1 = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(IDLE_GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sr_q, sr_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        accept_s;

  assign accept_s = req_valid && ready_q;

  // Next-state logic; every phase counts down from its length minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SHIFT_LO;
          cnt_d   = DIV_M1;
          bit_d   = 4'd15;
          sr_d    = {1'b1, req_addr, req_data};
        end else begin
          cnt_d   = 8'd0;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == 8'd0) begin
          state_d = SHIFT_HI;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q != 8'd0) begin
          cnt_d   = cnt_q - 8'd1;
        end else if (bit_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_M1;
          sr_d    = 16'd0;
        end else begin
          state_d = SHIFT_LO;
          cnt_d   = DIV_M1;
          bit_d   = bit_q - 4'd1;
          sr_d    = {sr_q[14:0], 1'b0};
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = GAP_M1;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          bit_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        bit_d   = 4'd0;
        sr_d    = 16'd0;
      end
    endcase
  end

  // Pin values are decoded from the next state so every output leaves a flop.
  always_comb begin
    ncs_d   = !((state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == HOLD));
    sclk_d  = (state_d == SHIFT_HI);
    copi_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? sr_d[15] : 1'b0;
    done_d  = (state_d == GAP) && (state_q != GAP);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      sr_q    <= 16'd0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ncs       = ncs_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;

endmodule

// File: tb/tb_spi_write_controller.sv
// Directed bench: dut0 uses default timing, dut1 the minimum (2/1/1); a passive
// SPI receiver per DUT decodes frames and measures ncs/sclk/done timing.
module tb_spi_write_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid [2];
  logic [6:0] req_addr  [2];
  logic [7:0] req_data  [2];
  logic       req_ready [2];
  logic       busy      [2];
  logic       done      [2];
  logic       ncs       [2];
  logic       sclk      [2];
  logic       copi      [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          acc_cyc [2], acc_prev [2], done_n [2], done_cyc [2];
  int          low_cnt [2], low_len [2], high_cnt [2], gap_len [2];
  int          nbits [2], last_rise [2], pmin [2], pmax [2];
  int          stab_err [2], ready_bad [2];
  logic [15:0] shreg [2];
  logic        copi_rise [2], prev_ncs [2], prev_sclk [2];
  logic [15:0] fq0 [$];
  logic [15:0] fq1 [$];
  logic [7:0]  regs [128];

  spi_write_controller dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_data(req_data[0]), .busy(busy[0]), .done(done[0]),
    .ncs(ncs[0]), .sclk(sclk[0]), .copi(copi[0])
  );

  spi_write_controller #(.CLK_DIV(2), .CS_HOLD(1), .IDLE_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_data(req_data[1]), .busy(busy[1]), .done(done[1]),
    .ncs(ncs[1]), .sclk(sclk[1]), .copi(copi[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Passive receiver, sampled mid-cycle on the falling clock edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_prev[i] = acc_cyc[i];
        acc_cyc[i]  = cyc;
      end
      if (done[i]) begin
        done_n[i]++;
        done_cyc[i] = cyc;
      end
      if (!ncs[i]) begin
        if (prev_ncs[i]) begin
          nbits[i] = 0; shreg[i] = 16'd0; low_cnt[i] = 0;
          gap_len[i] = high_cnt[i]; pmin[i] = 1000; pmax[i] = 0;
        end
        low_cnt[i]++;
        if (req_ready[i]) ready_bad[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          if (nbits[i] != 0) begin
            if (cyc - last_rise[i] < pmin[i]) pmin[i] = cyc - last_rise[i];
            if (cyc - last_rise[i] > pmax[i]) pmax[i] = cyc - last_rise[i];
          end
          last_rise[i] = cyc;
          shreg[i] = {shreg[i][14:0], copi[i]};
          copi_rise[i] = copi[i];
          nbits[i]++;
        end else if (sclk[i] && prev_sclk[i] && (copi[i] != copi_rise[i])) begin
          stab_err[i]++;
        end
      end else begin
        if (!prev_ncs[i]) begin
          low_len[i] = low_cnt[i];
          high_cnt[i] = 0;
          if (nbits[i] == 16) begin
            if (i == 0) begin
              fq0.push_back(shreg[i]);
              if (shreg[i][15]) regs[shreg[i][14:8]] = shreg[i][7:0];
            end else begin
              fq1.push_back(shreg[i]);
            end
          end
        end
        high_cnt[i]++;
      end
      prev_ncs[i]  = ncs[i];
      prev_sclk[i] = sclk[i];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present a request and wait for it to be taken; hold keeps req_valid high.
  task automatic send(input int i, input logic [6:0] a, input logic [7:0] d, input bit hold);
    bit ok = 1'b0;
    @(posedge clk);
    #2;
    req_valid[i] = 1'b1; req_addr[i] = a; req_data[i] = d;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
    end
    check("accept_timeout", int'(ok), 1);
    @(posedge clk);
    #2;
    if (!hold) req_valid[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      tick();
      if ((i == 0 ? fq0.size() : fq1.size()) >= n) ok = 1'b1;
    end
    check("frame_timeout", int'(ok), 1);
  endtask

  task automatic wait_bits(input int i, input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      tick();
      if (!ncs[i] && nbits[i] == n) ok = 1'b1;
    end
    check("bits_timeout", int'(ok), 1);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = 7'd0; req_data[i] = 8'd0;
      acc_cyc[i] = 0; acc_prev[i] = 0; done_n[i] = 0; done_cyc[i] = 0;
      low_cnt[i] = 0; low_len[i] = 0; high_cnt[i] = 0; gap_len[i] = 0;
      nbits[i] = 0; last_rise[i] = 0; pmin[i] = 1000; pmax[i] = 0;
      stab_err[i] = 0; ready_bad[i] = 0; shreg[i] = 16'd0;
      copi_rise[i] = 1'b0; prev_ncs[i] = 1'b1; prev_sclk[i] = 1'b0;
    end
    for (int r = 0; r < 128; r++) regs[r] = 8'h00;

    // Reset values
    repeat (3) tick();
    check("rst_ncs", int'(ncs[0]), 1);
    check("rst_sclk", int'(sclk[0]), 0);
    check("rst_copi", int'(copi[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_ready", int'(req_ready[0]), 1);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) tick();

    // 1: basic write
    send(0, 7'h00, 8'hA5, 1'b0);
    wait_frames(0, 1);
    check("t1_frame", int'(fq0[0]), 'h80A5);
    check("t1_ncs_low", low_len[0], 132);
    check("t1_acc_done", done_cyc[0] - acc_cyc[0], 133);
    repeat (10) tick();
    check("t1_done_cnt", done_n[0], 1);
    check("t1_reg0", int'(regs[0]), 'hA5);
    check("t1_copi_stable", stab_err[0], 0);

    // 2: boundary address/data values
    send(0, 7'h7F, 8'h00, 1'b0);
    wait_frames(0, 2);
    check("t2_frame_a", int'(fq0[1]), 'hFF00);
    send(0, 7'h04, 8'hFF, 1'b0);
    wait_frames(0, 3);
    check("t2_frame_b", int'(fq0[2]), 'h84FF);
    check("t2_reg4", int'(regs[4]), 'hFF);

    // 3: back-to-back with req_valid held
    repeat (12) tick();
    send(0, 7'h02, 8'h3C, 1'b1);
    send(0, 7'h03, 8'hC3, 1'b0);
    check("t3_accept_gap", acc_cyc[0] - acc_prev[0], 141);
    wait_frames(0, 5);
    check("t3_ncs_high", int'(gap_len[0] >= 8), 1);
    check("t3_frame_a", int'(fq0[3]), 'h823C);
    check("t3_frame_b", int'(fq0[4]), 'h83C3);

    // 4: request data changes while bit 10 is on the wire
    repeat (12) tick();
    send(0, 7'h05, 8'h55, 1'b0);
    wait_bits(0, 6);
    req_data[0] = 8'hAA;
    wait_frames(0, 6);
    check("t4_frame", int'(fq0[5]), 'h8555);
    check("t4_ready_low", ready_bad[0], 0);

    // 5: asynchronous reset during the high phase of bit 7
    repeat (12) tick();
    d0 = done_n[0];
    send(0, 7'h06, 8'h77, 1'b0);
    wait_bits(0, 9);
    rst_n = 1'b0;
    #1;
    check("t5_ncs", int'(ncs[0]), 1);
    check("t5_sclk", int'(sclk[0]), 0);
    check("t5_copi", int'(copi[0]), 0);
    repeat (3) tick();
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (150) tick();
    check("t5_no_done", done_n[0], d0);
    check("t5_no_frame", fq0.size(), 6);
    send(0, 7'h01, 8'h81, 1'b0);
    wait_frames(0, 7);
    check("t5_frame", int'(fq0[6]), 'h8181);
    check("t5_reg1", int'(regs[1]), 'h81);

    // 6: minimum timing parameters
    send(1, 7'h12, 8'h34, 1'b0);
    wait_frames(1, 1);
    repeat (4) tick();
    check("t6_frame", int'(fq1[0]), 'h9234);
    check("t6_ncs_low", low_len[1], 65);
    check("t6_period_min", pmin[1], 4);
    check("t6_period_max", pmax[1], 4);
    check("t6_copi_stable", stab_err[1], 0);
    check("t6_done_cnt", done_n[1], 1);
    check("t6_acc_done", done_cyc[1] - acc_cyc[1], 66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
